// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, sequencer states and memory-op helpers
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } seq_state_t;

    function automatic logic is_mem_read(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == ICALL) || (ic == IPUSHQ);
    endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// rtl/seq_perf_cnt.sv - saturating performance counter with synchronous clear
module seq_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - multi-cycle Y86-64 SEQ stage sequencer with memory handshake and status
module seq_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             cc_en,
    output logic             mem_req,
    output logic             mem_write,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    seq_state_t        state;
    logic [3:0]        icode_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_op;

    assign mem_op = is_mem_read(icode_q) || is_mem_write(icode_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            stat     <= SAOK;
            icode_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_FETCH;
                S_FETCH: begin
                    icode_q <= icode;
                    if (imem_error) begin
                        state <= S_HALTED;
                        stat  <= SADR;
                    end else if (!instr_valid) begin
                        state <= S_HALTED;
                        stat  <= SINS;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (icode_q == IHALT) begin
                        state <= S_HALTED;
                        stat  <= SHLT;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state    <= S_MEMORY;
                    wait_cnt <= '0;
                end
                S_MEMORY: begin
                    // A response arriving on the last allowed cycle still wins over the timeout.
                    if (!mem_op) begin
                        state <= S_WRITEBACK;
                    end else if (mem_ready) begin
                        wait_cnt <= '0;
                        if (dmem_error) begin
                            state <= S_HALTED;
                            stat  <= SADR;
                        end else begin
                            state <= S_WRITEBACK;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_HALTED;
                        stat     <= SADR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITEBACK: state <= S_PCUPD;
                S_PCUPD:     state <= S_FETCH;
                S_HALTED:    state <= S_HALTED;
                default:     state <= S_IDLE;
            endcase
        end
    end

    assign fetch_en   = (state == S_FETCH);
    assign decode_en  = (state == S_DECODE);
    assign execute_en = (state == S_EXECUTE);
    assign wb_en      = (state == S_WRITEBACK);
    assign pc_en      = (state == S_PCUPD);
    assign cc_en      = (state == S_EXECUTE) && (icode_q == IOPQ);
    assign mem_req    = (state == S_MEMORY) && mem_op;
    assign mem_write  = mem_req && is_mem_write(icode_q);
    assign busy       = (state != S_IDLE) && (state != S_HALTED);

    seq_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (busy),
        .count (cycle_count)
    );

    seq_perf_cnt #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (pc_en),
        .count (instr_count)
    );

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - self-checking bench for seq_ctrl
module tb_seq_ctrl;

    localparam int CW   = 6;
    localparam int TMO  = 16;
    localparam int CMAX = (1 << CW) - 1;

    // Output vector bits: fetch decode execute mem_req mem_write wb pc cc busy
    localparam logic [8:0] V_IDLE = 9'h000;
    localparam logic [8:0] V_F    = 9'h101;
    localparam logic [8:0] V_D    = 9'h081;
    localparam logic [8:0] V_E    = 9'h041;
    localparam logic [8:0] V_CC   = 9'h002;
    localparam logic [8:0] V_M    = 9'h001;
    localparam logic [8:0] V_MR   = 9'h021;
    localparam logic [8:0] V_MW   = 9'h031;
    localparam logic [8:0] V_W    = 9'h009;
    localparam logic [8:0] V_P    = 9'h005;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    icode = '0;
    logic          instr_valid = 1'b0;
    logic          imem_error = 1'b0;
    logic          mem_ready = 1'b0;
    logic          dmem_error = 1'b0;
    logic          fetch_en, decode_en, execute_en, wb_en, pc_en, cc_en;
    logic          mem_req, mem_write, busy;
    logic [2:0]    stat;
    logic [CW-1:0] cycle_count, instr_count;
    logic [8:0]    dut_vec;

    seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .execute_en  (execute_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .cc_en       (cc_en),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .stat        (stat),
        .busy        (busy),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    assign dut_vec = {fetch_en, decode_en, execute_en, mem_req, mem_write,
                      wb_en, pc_en, cc_en, busy};

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_cyc = 0;
    int m_ins = 0;
    int m_stat = 1;

    typedef struct {
        logic [3:0] ic;
        logic       ie;
        logic       iv;
        int         lat;
        logic       de;
        int         es;
        int         eins;
        int         ecyc;
    } vec_t;

    vec_t tbl[10];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rnib();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enter at negedge: compare, drive this cycle's inputs, advance one clock.
    task automatic do_cycle(input string tag, input logic [8:0] ev, input logic st,
                            input logic [3:0] ic, input logic iv, input logic ie,
                            input logic mr, input logic de);
        check({tag, " enables"}, int'(dut_vec), int'(ev));
        check({tag, " stat"}, int'(stat), m_stat);
        check({tag, " cycle_count"}, int'(cycle_count), m_cyc);
        check({tag, " instr_count"}, int'(instr_count), m_ins);
        start = st; icode = ic; instr_valid = iv; imem_error = ie;
        mem_ready = mr; dmem_error = de;
        @(posedge clk);
        if (ev[0] && m_cyc < CMAX) m_cyc++;
        if (ev[2] && m_ins < CMAX) m_ins++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b1; dmem_error = rb();
        icode = rnib(); instr_valid = rb(); imem_error = rb();
        @(posedge clk);
        m_cyc = 0; m_ins = 0; m_stat = 1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_start();
        do_cycle("idle", V_IDLE, 1'b0, rnib(), rb(), rb(), rb(), rb());
        do_cycle("start", V_IDLE, 1'b1, rnib(), rb(), rb(), rb(), rb());
    endtask

    // lat >= TMO means mem_ready never comes; stop_m >= 0 abandons the instruction
    // just before that MEMORY cycle.
    task automatic run_instr(input logic [3:0] ic, input logic ie, input logic iv,
                             input int lat, input logic de, input int stop_m,
                             output bit halted);
        bit rd, wr, rdy;
        halted = 0;
        rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        do_cycle("fetch", V_F, rb(), ic, iv, ie, rb(), rb());
        if (ie) begin m_stat = 3; halted = 1; return; end
        if (!iv) begin m_stat = 4; halted = 1; return; end
        do_cycle("decode", V_D, rb(), rnib(), rb(), rb(), rb(), rb());
        if (ic == 4'h0) begin m_stat = 2; halted = 1; return; end
        do_cycle("execute", (ic == 4'h6) ? (V_E | V_CC) : V_E, rb(), rnib(), rb(), rb(), rb(), rb());
        if (rd || wr) begin
            for (int k = 0; k < TMO; k++) begin
                if (k == stop_m) return;
                rdy = (k == lat);
                do_cycle("memory", wr ? V_MW : V_MR, rb(), rnib(), rb(), rb(), rdy, rdy ? de : rb());
                if (rdy) begin
                    if (de) begin m_stat = 3; halted = 1; return; end
                    break;
                end
            end
            if (lat >= TMO) begin m_stat = 3; halted = 1; return; end
        end else begin
            do_cycle("memory", V_M, rb(), rnib(), rb(), rb(), rb(), rb());
        end
        do_cycle("writeback", V_W, rb(), rnib(), rb(), rb(), rb(), rb());
        do_cycle("pcupd", V_P, rb(), rnib(), rb(), rb(), rb(), rb());
    endtask

    task automatic halted_cycles(input int n);
        for (int i = 0; i < n; i++)
            do_cycle("halted", V_IDLE, rb(), rnib(), rb(), rb(), rb(), rb());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        int r;
        logic [3:0] ic;
        tbl[0] = '{4'h1, 1'b0, 1'b1, 0,   1'b0, 1, 1, 6};
        tbl[1] = '{4'h5, 1'b0, 1'b1, 3,   1'b0, 1, 1, 9};
        tbl[2] = '{4'h4, 1'b0, 1'b1, 99,  1'b0, 3, 0, 19};
        tbl[3] = '{4'h0, 1'b0, 1'b1, 0,   1'b0, 2, 0, 2};
        tbl[4] = '{4'h1, 1'b1, 1'b0, 0,   1'b0, 3, 0, 1};
        tbl[5] = '{4'h1, 1'b0, 1'b0, 0,   1'b0, 4, 0, 1};
        tbl[6] = '{4'hA, 1'b0, 1'b1, 0,   1'b1, 3, 0, 4};
        tbl[7] = '{4'h6, 1'b0, 1'b1, 0,   1'b0, 1, 1, 6};
        tbl[8] = '{4'h9, 1'b0, 1'b1, 15,  1'b0, 1, 1, 21};
        tbl[9] = '{4'h8, 1'b0, 1'b1, 0,   1'b0, 1, 1, 6};

        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            idle_start();
            run_instr(tbl[t].ic, tbl[t].ie, tbl[t].iv, tbl[t].lat, tbl[t].de, -1, h);
            check($sformatf("tbl%0d stat", t), int'(stat), tbl[t].es);
            check($sformatf("tbl%0d instr_count", t), int'(instr_count), tbl[t].eins);
            check($sformatf("tbl%0d cycle_count", t), int'(cycle_count), tbl[t].ecyc);
            check($sformatf("tbl%0d busy", t), int'(busy), (tbl[t].es == 1) ? 1 : 0);
            if (h) halted_cycles(3);
        end

        // OPq then halt: halt never reaches write-back or PC update
        do_reset();
        idle_start();
        run_instr(4'h6, 1'b0, 1'b1, 0, 1'b0, -1, h);
        run_instr(4'h0, 1'b0, 1'b1, 0, 1'b0, -1, h);
        check("opq_halt stat", int'(stat), 2);
        check("opq_halt instr_count", int'(instr_count), 1);
        check("opq_halt cycle_count", int'(cycle_count), 8);
        halted_cycles(4);

        // Reset while pushq waits in MEMORY, with a response arriving during reset
        do_reset();
        idle_start();
        run_instr(4'hA, 1'b0, 1'b1, 99, 1'b0, 3, h);
        check("midreq mem_req before reset", int'(mem_req), 1);
        do_reset();
        check("midreq mem_req", int'(mem_req), 0);
        check("midreq busy", int'(busy), 0);
        check("midreq fetch_en", int'(fetch_en), 0);
        check("midreq stat", int'(stat), 1);
        check("midreq cycle_count", int'(cycle_count), 0);
        check("midreq instr_count", int'(instr_count), 0);
        for (int i = 0; i < 3; i++)
            do_cycle("post_reset_idle", V_IDLE, 1'b0, rnib(), rb(), rb(), rb(), rb());

        // Counter saturation at all-ones
        do_reset();
        idle_start();
        for (int i = 0; i < 66; i++) run_instr(4'h1, 1'b0, 1'b1, 0, 1'b0, -1, h);
        check("sat cycle_count", int'(cycle_count), CMAX);
        check("sat instr_count", int'(instr_count), CMAX);

        // Randomized instruction stream against the reference model
        do_reset();
        idle_start();
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 79);
            ic = 4'($urandom_range(1, 11));
            case (r)
                0: run_instr(ic, 1'b1, rb(), 0, 1'b0, -1, h);
                1: run_instr(ic, 1'b0, 1'b0, 0, 1'b0, -1, h);
                2: run_instr(4'h0, 1'b0, 1'b1, 0, 1'b0, -1, h);
                3: run_instr(ic, 1'b0, 1'b1, 99, 1'b0, -1, h);
                4: run_instr(ic, 1'b0, 1'b1, $urandom_range(0, 4), 1'b1, -1, h);
                default: run_instr(ic, 1'b0, 1'b1, $urandom_range(0, 4), 1'b0, -1, h);
            endcase
            if (h) begin
                halted_cycles(2);
                do_reset();
                idle_start();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
